// File: rtl/fc_stream_pkg.sv
// Shared types and helpers for the streaming fully connected layer:
// controller states, accumulator width rule, ReLU and output saturation.
package fc_stream_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    BIAS   = 2'd1,
    OUTPUT = 2'd2
  } fc_state_e;

  // Helpers work on a wide signed intermediate so they are independent of
  // the instance widths; callers sign-extend in and truncate out.
  localparam int WIDE_W = 64;

  // Smallest accumulator that holds a full-length dot product of
  // px_size-bit operands without wrapping.
  function automatic int min_acc_width(input int px_size, input int in_features);
    return 2 * px_size + $clog2(in_features);
  endfunction

  // Clamp negatives to zero when enabled.
  function automatic logic signed [WIDE_W-1:0] relu_w(input logic signed [WIDE_W-1:0] v,
                                                      input bit en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  // Saturate to the signed px_size-bit range.
  function automatic logic signed [WIDE_W-1:0] sat_px(input logic signed [WIDE_W-1:0] v,
                                                      input int px_size);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (px_size - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (px_size - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_layer_stream_lane.sv
// One MAC lane of the streaming fully connected layer: owns the weight row
// and bias of a single output feature, its accumulator and its registered,
// rectified and saturated result.
module fc_mac_lane
  import fc_stream_pkg::*;
#(
  parameter int    IN_FEATURES  = 75,
  parameter int    OUT_FEATURES = 3,
  parameter int    PX_SIZE      = 8,
  parameter int    ACC_SIZE     = 24,
  parameter int    FRAC_BITS    = 0,
  parameter int    RELU         = 1,
  parameter int    LANE         = 0,
  parameter int    IDX_W        = 7,
  parameter string WEIGHT_FILE  = "weights.coe",
  parameter string BIAS_FILE    = "biases.coe",
  parameter logic [OUT_FEATURES*IN_FEATURES*PX_SIZE-1:0] WEIGHT_INIT = '0,
  parameter logic [OUT_FEATURES*PX_SIZE-1:0]             BIAS_INIT   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_mac_i,
  input  logic                      en_bias_i,
  input  logic                      clr_i,
  input  logic signed [PX_SIZE-1:0] pixel_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic signed [PX_SIZE-1:0] res_o
);

  logic [PX_SIZE-1:0]        w_img [OUT_FEATURES*IN_FEATURES];
  logic [PX_SIZE-1:0]        b_img [OUT_FEATURES];
  logic signed [PX_SIZE-1:0] w_rom [IN_FEATURES];
  logic signed [PX_SIZE-1:0] b_rom;

  logic signed [PX_SIZE-1:0]   w_cur;
  logic signed [2*PX_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
  logic signed [ACC_SIZE-1:0]  acc_bias;
  logic signed [ACC_SIZE-1:0]  acc_shr;
  logic signed [WIDE_W-1:0]    acc_wide;
  logic signed [WIDE_W-1:0]    clipped;
  logic signed [PX_SIZE-1:0]   res_q, res_d;

  // ROM image from the packed init parameters.
  initial begin
    for (int k = 0; k < OUT_FEATURES*IN_FEATURES; k++)
      w_img[k] = WEIGHT_INIT[k*PX_SIZE +: PX_SIZE];
    for (int k = 0; k < OUT_FEATURES; k++)
      b_img[k] = BIAS_INIT[k*PX_SIZE +: PX_SIZE];
    for (int i = 0; i < IN_FEATURES; i++)
      w_rom[i] = w_img[LANE*IN_FEATURES + i];
    b_rom = b_img[LANE];
  end

  // Multiply-accumulate, bias injection and result formatting.
  always_comb begin
    w_cur    = w_rom[idx_i];
    prod     = (2*PX_SIZE)'(pixel_i) * (2*PX_SIZE)'(w_cur);
    acc_bias = acc_q + (ACC_SIZE'(b_rom) <<< FRAC_BITS);
    acc_shr  = acc_bias >>> FRAC_BITS;
    acc_wide = WIDE_W'(acc_shr);
    clipped  = sat_px(relu_w(acc_wide, RELU != 0), PX_SIZE);
    acc_d    = acc_q;
    res_d    = res_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_mac_i) begin
      acc_d = acc_q + ACC_SIZE'(prod);
    end else if (en_bias_i) begin
      acc_d = acc_bias;
      res_d = clipped[PX_SIZE-1:0];
    end
  end

  // Accumulator and result registers; result holds until the next bias step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully connected layer: one pixel per handshake, OUT_FEATURES
// parallel MAC lanes, bias + optional ReLU + rescale/saturate, result vector
// on a valid/ready port. Frame length is counted; in_last is only checked.
module fc_layer_stream
  import fc_stream_pkg::*;
#(
  parameter int    IN_FEATURES  = 75,
  parameter int    OUT_FEATURES = 3,
  parameter int    PX_SIZE      = 8,
  parameter int    ACC_SIZE     = 24,
  parameter int    FRAC_BITS    = 0,
  parameter int    RELU         = 1,
  parameter string WEIGHT_FILE  = "weights.coe",
  parameter string BIAS_FILE    = "biases.coe",
  parameter logic [OUT_FEATURES*IN_FEATURES*PX_SIZE-1:0] WEIGHT_INIT = '0,
  parameter logic [OUT_FEATURES*PX_SIZE-1:0]             BIAS_INIT   = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [PX_SIZE-1:0]             in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_FEATURES-1:0][PX_SIZE-1:0]  out_data,
  output logic                                  err_len
);

  localparam int              IDX_W    = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_FEATURES - 1);

  if (ACC_SIZE < min_acc_width(PX_SIZE, IN_FEATURES)) begin : g_acc_width_chk
    $error("fc_layer_stream: ACC_SIZE narrower than 2*PX_SIZE+clog2(IN_FEATURES)");
  end

  fc_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             en_mac, en_bias, clr;
  logic             last_px;

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == OUTPUT);
  assign err_len   = err_q;

  // Next-state, pixel counter and length check.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    en_mac  = 1'b0;
    en_bias = 1'b0;
    clr     = 1'b0;
    last_px = (idx_q == IDX_LAST);
    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          en_mac = 1'b1;
          err_d  = (in_last != last_px);
          if (last_px) begin
            idx_d   = '0;
            state_d = BIAS;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      BIAS: begin
        en_bias = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  for (genvar c = 0; c < OUT_FEATURES; c++) begin : g_lane
    fc_mac_lane #(
      .IN_FEATURES (IN_FEATURES),
      .OUT_FEATURES(OUT_FEATURES),
      .PX_SIZE     (PX_SIZE),
      .ACC_SIZE    (ACC_SIZE),
      .FRAC_BITS   (FRAC_BITS),
      .RELU        (RELU),
      .LANE        (c),
      .IDX_W       (IDX_W),
      .WEIGHT_FILE (WEIGHT_FILE),
      .BIAS_FILE   (BIAS_FILE),
      .WEIGHT_INIT (WEIGHT_INIT),
      .BIAS_INIT   (BIAS_INIT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en_mac_i (en_mac),
      .en_bias_i(en_bias),
      .clr_i    (clr),
      .pixel_i  (in_data),
      .idx_i    (idx_q),
      .res_o    (out_data[c])
    );
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream with IN_FEATURES=4, OUT_FEATURES=2,
// W0={1,1,1,1}, W1={1,-1,2,0}, B={0,5}. Two instances: ReLU on and off.
module tb_fc_layer_stream;

  localparam int NI = 4;
  localparam int NO = 2;
  localparam int PX = 8;
  localparam logic [NO*NI*PX-1:0] W_INIT = 64'h0002FF01_01010101;
  localparam logic [NO*PX-1:0]    B_INIT = 16'h0500;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid, in_last, out_ready;
  logic signed [PX-1:0]       in_data;
  logic                       in_ready, out_valid, err_len;
  logic                       in_ready_nr, out_valid_nr, err_len_nr;
  logic [NO-1:0][PX-1:0]      out_data, out_data_nr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fc_layer_stream #(
    .IN_FEATURES(NI), .OUT_FEATURES(NO), .PX_SIZE(PX), .ACC_SIZE(24),
    .FRAC_BITS(0), .RELU(1), .WEIGHT_FILE(""), .BIAS_FILE(""),
    .WEIGHT_INIT(W_INIT), .BIAS_INIT(B_INIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_len(err_len)
  );

  fc_layer_stream #(
    .IN_FEATURES(NI), .OUT_FEATURES(NO), .PX_SIZE(PX), .ACC_SIZE(24),
    .FRAC_BITS(0), .RELU(0), .WEIGHT_FILE(""), .BIAS_FILE(""),
    .WEIGHT_INIT(W_INIT), .BIAS_INIT(B_INIT)
  ) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_nr),
    .out_ready(out_ready), .out_data(out_data_nr), .err_len(err_len_nr)
  );

  typedef struct {
    string          name;
    logic [3:0][7:0] px;
    logic [3:0]     lst;
    int             n_err;
    int             e0, e1;   // RELU=1
    int             n0, n1;   // RELU=0
  } vec_t;

  function automatic vec_t mk(input string nm, input int p0, input int p1, input int p2,
                              input int p3, input logic [3:0] lst, input int ne,
                              input int e0, input int e1, input int n0, input int n1);
    vec_t v;
    v.name  = nm;
    v.px    = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    v.lst   = lst;
    v.n_err = ne;
    v.e0 = e0; v.e1 = e1; v.n0 = n0; v.n1 = n1;
    return v;
  endfunction

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Drive four pixels back-to-back from negedges, then wait (bounded) for
  // out_valid. lat counts cycles from the last pixel's cycle to out_valid.
  task automatic send_frame(input logic [3:0][7:0] px, input logic [3:0] lst,
                            output int lat, output int errs, output int errs_nr);
    errs = 0; errs_nr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        errs    += int'(err_len);
        errs_nr += int'(err_len_nr);
      end
      in_valid = 1'b1;
      in_data  = px[i];
      in_last  = lst[i];
    end
    @(negedge clk);
    errs    += int'(err_len);
    errs_nr += int'(err_len_nr);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      errs    += int'(err_len);
      errs_nr += int'(err_len_nr);
    end
  endtask

  task automatic check_result(input string nm, input int lat, input int e0, input int e1);
    check({nm, "_lat"}, lat, 2);
    check({nm, "_out0"}, $signed(out_data[0]), e0);
    check({nm, "_out1"}, $signed(out_data[1]), e1);
  endtask

  vec_t tv [10];
  int   lat, errs, errs_nr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = mk("basic",     1,   2,   3,   4, 4'b1000, 0,  10,  10,   10,   10);
    tv[1] = mk("sat_pos", 127, 127, 127, 127, 4'b1000, 0, 127, 127,  127,  127);
    tv[2] = mk("relu",    -10,   0,   0,   0, 4'b1000, 0,   0,   0,  -10,   -5);
    tv[3] = mk("ones",      1,   1,   1,   1, 4'b1000, 0,   4,   7,    4,    7);
    tv[4] = mk("sat_neg",-128,-128,-128,-128, 4'b1000, 0,   0,   0, -128, -128);
    tv[5] = mk("mixed",     5,  -3, -20,   7, 4'b1000, 0,   0,   0,  -11,  -27);
    tv[6] = mk("one_neg",   0,  10,   0,   0, 4'b1000, 0,  10,   0,   10,   -5);
    tv[7] = mk("early_last",1,   2,   3,   4, 4'b1010, 1,  10,  10,   10,   10);
    tv[8] = mk("no_last",   1,   2,   3,   4, 4'b0000, 1,  10,  10,   10,   10);
    tv[9] = mk("only_early",1,   2,   3,   4, 4'b0010, 2,  10,  10,   10,   10);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_len", err_len, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven frames
    for (int k = 0; k < 10; k++) begin
      send_frame(tv[k].px, tv[k].lst, lat, errs, errs_nr);
      check_result(tv[k].name, lat, tv[k].e0, tv[k].e1);
      check($sformatf("%s_err", tv[k].name), errs, tv[k].n_err);
      check($sformatf("%s_err_nr", tv[k].name), errs_nr, tv[k].n_err);
      check($sformatf("%s_vld_nr", tv[k].name), out_valid_nr, 1);
      check($sformatf("%s_nr0", tv[k].name), $signed(out_data_nr[0]), tv[k].n0);
      check($sformatf("%s_nr1", tv[k].name), $signed(out_data_nr[1]), tv[k].n1);
      @(negedge clk);
      check($sformatf("%s_vld_drop", tv[k].name), out_valid, 0);
      check($sformatf("%s_rdy_back", tv[k].name), in_ready, 1);
      check($sformatf("%s_rdy_back_nr", tv[k].name), in_ready_nr, 1);
    end

    // Backpressure: result held, extra beats ignored, no leftover afterwards
    out_ready = 1'b0;
    send_frame(tv[0].px, 4'b1000, lat, errs, errs_nr);
    check_result("bp", lat, 10, 10);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'sd50; in_last = 1'b1;
      @(negedge clk);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_out0", $signed(out_data[0]), 10);
      check("bp_hold_out1", $signed(out_data[1]), 10);
      check("bp_in_ready", in_ready, 0);
      check("bp_err_len", err_len, 0);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_vld", out_valid, 0);
    send_frame(tv[3].px, 4'b1000, lat, errs, errs_nr);
    check_result("bp_next", lat, 4, 7);
    check("bp_next_err", errs, 0);
    @(negedge clk);

    // Reset mid-frame: partial frame discarded
    in_valid = 1'b1; in_data = 8'sd7; in_last = 1'b0;
    @(negedge clk);
    in_data = 8'sd9;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(tv[0].px, 4'b1000, lat, errs, errs_nr);
    check_result("midrst", lat, 10, 10);
    check("midrst_nr1", $signed(out_data_nr[1]), 10);
    @(negedge clk);

    // Reset while a result is pending
    out_ready = 1'b0;
    send_frame(tv[0].px, 4'b1000, lat, errs, errs_nr);
    check_result("outrst_pre", lat, 10, 10);
    rst = 1'b1;
    @(negedge clk);
    check("outrst_vld", out_valid, 0);
    check("outrst_data", out_data, 0);
    rst = 1'b0; out_ready = 1'b1;
    send_frame(tv[3].px, 4'b1000, lat, errs, errs_nr);
    check_result("outrst_next", lat, 4, 7);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_stream.md
Name: fc_layer_stream

Overview:
- Time-multiplexed, streaming successor to the fully connected layer. Consumes a flattened input feature map one pixel per handshake and computes all OUT_FEATURES dot products in parallel, one lane per output feature.
- Adds bias, optionally applies ReLU, then rescales and saturates. Presents the result vector on a valid/ready output.
- Sits after the last conv/pool stage. Its output feeds the classifier argmax or the next fc_layer_stream.

Parameters:
- IN_FEATURES, 75, flattened input length (5*5*3).
- OUT_FEATURES, 3, output features = parallel MAC lanes.
- PX_SIZE, 8, bits per pixel/weight/bias/output, signed two's complement.
- ACC_SIZE, 24, accumulator width; must be >= 2*PX_SIZE + clog2(IN_FEATURES).
- FRAC_BITS, 0, fixed-point fraction bits of weights; output = acc >>> FRAC_BITS.
- RELU, 1, 1 = clamp negative results to 0 before saturation.
- WEIGHT_FILE, "weights.coe", $readmemb image, OUT_FEATURES*IN_FEATURES words, feature-major (c*IN_FEATURES+i).
- BIAS_FILE, "biases.coe", $readmemb image, OUT_FEATURES words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  PX_SIZE  signed input pixel.
- in_last  in  1  marks the final pixel of a frame.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  [OUT_FEATURES-1:0][PX_SIZE-1:0]  signed results; index c = feature c.
- err_len  out  1  one-cycle pulse when in_last disagrees with the pixel count.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Weights and biases are internal ROMs loaded by $readmemb at init.
- Reset values: in_ready=0 during rst and 1 the cycle after; out_valid=0; out_data=0; err_len=0; idx=0; all accumulators=0; state=ACCUM.
- FSM states: ACCUM, BIAS, OUTPUT.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready, each lane c does acc[c] += sext(in_data*W[c][idx]), full 2*PX_SIZE product.
  - idx increments on each accepted pixel.
  - When idx==IN_FEATURES-1 is accepted: idx wraps to 0 and the state goes to BIAS.
- BIAS (1 cycle):
  - in_ready=0.
  - acc[c] += sext(B[c]) << FRAC_BITS.
  - Go to OUTPUT.
- OUTPUT:
  - in_ready=0 and out_valid=1.
  - out_data[c] = sat(relu(acc[c] >>> FRAC_BITS)), using an arithmetic shift. sat clamps to [-2^(PX_SIZE-1), 2^(PX_SIZE-1)-1].
  - out_data is registered and stable while out_valid && !out_ready.
  - On out_ready: accumulators clear to 0, out_valid drops next cycle, state returns to ACCUM.
- Latency: out_valid rises exactly 2 cycles after the handshake of the final pixel.
- Throughput: IN_FEATURES+2 cycles per frame when out_ready is held high.
- Frame length is count-driven; in_last is only checked:
  - in_last=1 on a pixel with idx != IN_FEATURES-1 gives an err_len pulse the next cycle; accumulation continues.
  - in_last=0 on the final pixel also pulses err_len. The frame still completes.
- The accumulator never wraps in range. ACC_SIZE sizing is the integrator's responsibility; a static assertion checks the width rule.
- in_valid while in_ready=0 is ignored, and the pixel is not consumed.
- rst mid-frame or mid-OUTPUT discards the partial frame and any pending result; out_valid drops the next cycle.

Decomposition:
- Package fc_stream_pkg holds:
  - the state enum (ACCUM, BIAS, OUTPUT);
  - the function sat_px(acc) and the ReLU helper;
  - the localparam width rule as a function clog2-based min_acc_width().
- Sub-module fc_mac_lane, one per output feature:
  - holds its own weight ROM slice, bias, and accumulator;
  - inputs: en_mac, en_bias, clr, pixel, idx;
  - output: saturated result.
- Top level holds the FSM, idx counter, handshakes, err_len logic and the generate loop over lanes.

Test Plan (IN_FEATURES=4, OUT_FEATURES=2, PX_SIZE=8, FRAC_BITS=0; W0={1,1,1,1}, W1={1,-1,2,0}, B={0,5}):
- Basic: pixels 1,2,3,4 back-to-back, in_last on the 4th, out_ready=1 -> out_valid 2 cycles after pixel 4 with out_data={10,10}; single-cycle pulse; in_ready high again the next cycle.
- Saturation: pixels 127,127,127,127 -> feature0 = 508, saturated to 127; feature1 = 127-127+254+5 = 259, saturated to 127.
- ReLU: RELU=1, pixels -10,0,0,0 -> {0,0}. With RELU=0 -> {-10,-5}.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data held stable, in_ready=0, extra in_valid beats not consumed. Release -> next frame 1,1,1,1 gives {4,7}, with no leftover accumulation.
- Length error: in_last on the 2nd pixel of 1,2,3,4 -> err_len pulses once, result still {10,10}. Frame with no in_last -> err_len pulse after pixel 4.
- Reset mid-frame: assert rst after 2 pixels, then send 1,2,3,4 -> {10,10}. Repeat with rst while out_valid=1 -> out_valid=0 the next cycle.
